instr_mem_ctrl: RTL and testbench

//  Parametrised, synchronous-read instruction memory for the fetch stage. It replaces the earlier

---
 rtl/instr_mem_ctrl_pkg.sv | 32 +++
 rtl/instr_mem_ctrl_if.sv | 27 ++
 rtl/instr_mem_ctrl_array.sv | 41 ++++
 rtl/instr_mem_ctrl.sv | 108 ++++++++++
 tb/tb_instr_mem_ctrl.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/instr_mem_ctrl_pkg.sv
// Shared types and address decoding for the instruction memory controller.
// Optional feature macro: INSTR_MEM_PARITY_EN (adds a stored even-parity bit per word).
package instr_mem_pkg;

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'b00,
    FAULT_MISALIGN = 2'b01,
    FAULT_RANGE    = 2'b10,
    FAULT_PARITY   = 2'b11
  } fault_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  // Classifies a byte address against a word array of 2**idx_w entries whose
  // words span 2**off_w bytes. Misalignment wins over out-of-range. Loads pass
  // ignore_low=1 because their low byte bits are simply discarded. Addresses
  // are zero-extended to 64 bits by the caller, so ADDR_W must not exceed 64.
  function automatic fault_e addr_decode(input logic [63:0] addr,
                                         input int unsigned off_w,
                                         input int unsigned idx_w,
                                         input logic ignore_low);
    logic [63:0] low_mask;
    low_mask = (64'd1 << off_w) - 64'd1;
    if (!ignore_low && ((addr & low_mask) != 64'd0)) return FAULT_MISALIGN;
    if ((addr >> (off_w + idx_w)) != 64'd0) return FAULT_RANGE;
    return FAULT_NONE;
  endfunction

endpackage

// File: rtl/instr_mem_ctrl_if.sv
// Fetch and loader bus of the instruction memory. The memory is the slave,
// the fetch stage / program loader side is the master.
interface instr_mem_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              reqValid;
  logic              reqReady;
  logic [ADDR_W-1:0] reqAddr;
  logic              rspValid;
  logic              rspReady;
  logic [DATA_W-1:0] rspData;
  logic [1:0]        rspFault;
  logic              loadEn;
  logic [ADDR_W-1:0] loadAddr;
  logic [DATA_W-1:0] loadData;

  modport master (
    output reqValid, reqAddr, rspReady, loadEn, loadAddr, loadData,
    input  reqReady, rspValid, rspData, rspFault
  );

  modport slave (
    input  reqValid, reqAddr, rspReady, loadEn, loadAddr, loadData,
    output reqReady, rspValid, rspData, rspFault
  );
endinterface

// File: rtl/instr_mem_ctrl_array.sv
// Word storage: one write port, one registered read port. A read and a write
// to the same word on the same edge return the word as it was before the write.
module instr_mem_array #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 64,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [WIDTH-1:0] wr_word,
  input  logic             rd_en,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [WIDTH-1:0] rd_word
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_word_q;
  logic [WIDTH-1:0] rd_word_d;

  // Capture the addressed word only on a read, otherwise hold the last word.
  always_comb begin
    rd_word_d = rd_word_q;
    if (rd_en) rd_word_d = mem_q[rd_idx];
  end

  // Read register clears on reset so the response data starts at zero.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) rd_word_q <= '0;
    else         rd_word_q <= rd_word_d;
  end

  // Storage itself is never reset; a program survives a reset pulse.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= wr_word;
  end

  assign rd_word = rd_word_q;

endmodule

// File: rtl/instr_mem_ctrl.sv
// Synchronous-read instruction memory for the fetch stage: byte-addressed
// req/rsp handshake with one cycle latency, a write-only loader port, and
// fault reporting for misaligned, out-of-range and (optionally) parity errors.
// Optional feature macro: INSTR_MEM_PARITY_EN.
module instr_mem_ctrl
  import instr_mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 32
) (
  input  logic             clk,
  input  logic             resetN,
  instr_mem_ctrl_if.slave  bus
);

  localparam int unsigned OFF_W = $clog2(DATA_W / 8);
  localparam int unsigned IDX_W = $clog2(DEPTH);
`ifdef INSTR_MEM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  state_e             state_q, state_d;
  fault_e             fault_q, fault_d;
  fault_e             req_fault;
  fault_e             load_fault;
  logic               accept;
  logic               rd_en;
  logic               wr_en;
  logic [IDX_W-1:0]   rd_idx;
  logic [IDX_W-1:0]   wr_idx;
  logic [MEM_W-1:0]   wr_word;
  logic [MEM_W-1:0]   rd_word;
  logic               parity_err;

  // Classify both incoming addresses; loads only care about range.
  always_comb begin
    req_fault  = addr_decode(64'(bus.reqAddr), OFF_W, IDX_W, 1'b0);
    load_fault = addr_decode(64'(bus.loadAddr), OFF_W, IDX_W, 1'b1);
  end

  assign rd_idx = bus.reqAddr[OFF_W +: IDX_W];
  assign wr_idx = bus.loadAddr[OFF_W +: IDX_W];

  // A new request fits whenever the output register is empty or draining now.
  assign bus.reqReady = (state_q == ST_EMPTY) || bus.rspReady;
  assign accept       = bus.reqValid && bus.reqReady;
  assign rd_en        = accept && (req_fault == FAULT_NONE);
  assign wr_en        = bus.loadEn && (load_fault == FAULT_NONE);

`ifdef INSTR_MEM_PARITY_EN
  assign wr_word = {^bus.loadData, bus.loadData};
`else
  assign wr_word = bus.loadData;
`endif

  instr_mem_array #(
    .WIDTH (MEM_W),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk     (clk),
    .resetN  (resetN),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_word (wr_word),
    .rd_en   (rd_en),
    .rd_idx  (rd_idx),
    .rd_word (rd_word)
  );

  // Next-state of the output register: fill on accept, drain when consumed.
  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    if (accept) begin
      state_d = ST_FULL;
      fault_d = req_fault;
    end else if (bus.rspReady) begin
      state_d = ST_EMPTY;
    end
  end

  // Handshake state and the latched fault code of the current response.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= ST_EMPTY;
      fault_q <= FAULT_NONE;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
    end
  end

  // The parity check only means something when the array was actually read.
`ifdef INSTR_MEM_PARITY_EN
  assign parity_err = (fault_q == FAULT_NONE) && (^rd_word);
`else
  assign parity_err = 1'b0;
`endif

  assign bus.rspValid = (state_q == ST_FULL);
  assign bus.rspFault = parity_err ? FAULT_PARITY : fault_q;
  assign bus.rspData  = ((fault_q != FAULT_NONE) || parity_err) ? '0 : rd_word[DATA_W-1:0];

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Scoreboard bench for instr_mem_ctrl: directed scenarios plus randomized
// traffic, checked against a word-array model of the memory.
`timescale 1ns/1ps
module tb_instr_mem_ctrl;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 32;
  localparam logic [31:0] BYTES = 32'(DEPTH * 4);

  typedef struct {
    logic [31:0] data;
    logic [1:0]  fault;
  } rsp_t;

  logic clk    = 1'b0;
  logic resetN = 1'b0;

  instr_mem_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  instr_mem_ctrl #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] model_mem  [DEPTH];
  bit          parity_bad [DEPTH];
  rsp_t        exp_q [$];
  int unsigned vec_cnt = 0;
  int unsigned err_cnt = 0;

  // Reference behaviour of one fetch against the model contents.
  function automatic rsp_t model_fetch(input logic [31:0] addr);
    rsp_t       r;
    logic [5:0] idx;
    idx     = addr[7:2];
    r.data  = 32'd0;
    r.fault = 2'b00;
    if (addr[1:0] != 2'b00)    r.fault = 2'b01;
    else if (addr >= BYTES)    r.fault = 2'b10;
    else if (parity_bad[idx])  r.fault = 2'b11;
    else                       r.data  = model_mem[idx];
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle of stimulus just after the rising edge.
  task automatic applyStimulus(input bit rv, input logic [31:0] ra, input bit rr,
                               input bit le, input logic [31:0] la, input logic [31:0] ld);
    @(posedge clk);
    #1;
    bus.reqValid = rv;
    bus.reqAddr  = ra;
    bus.rspReady = rr;
    bus.loadEn   = le;
    bus.loadAddr = la;
    bus.loadData = ld;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 32'd0);
  endtask

  // Monitor: compares the visible response with the scoreboard head, then
  // records what this edge will accept or write.
  always @(negedge clk) begin
    if (!resetN) begin
      exp_q.delete();
    end else begin : mon_blk
      bit exp_valid;
      bit exp_ready;
      exp_valid = (exp_q.size() != 0);
      exp_ready = !exp_valid || bus.rspReady;
      checkOutput("rspValid", 32'(bus.rspValid), 32'(exp_valid));
      checkOutput("reqReady", 32'(bus.reqReady), 32'(exp_ready));
      if (exp_valid) begin
        checkOutput("rspData", bus.rspData, exp_q[0].data);
        checkOutput("rspFault", 32'(bus.rspFault), 32'(exp_q[0].fault));
        if (bus.rspReady) void'(exp_q.pop_front());
      end
      if (bus.reqValid && exp_ready) exp_q.push_back(model_fetch(bus.reqAddr));
      if (bus.loadEn && (bus.loadAddr < BYTES)) begin
        model_mem[bus.loadAddr[7:2]]  = bus.loadData;
        parity_bad[bus.loadAddr[7:2]] = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] ra, la;
    int          kind;

    bus.reqValid = 1'b1;
    bus.reqAddr  = 32'h8;
    bus.rspReady = 1'b1;
    bus.loadEn   = 1'b0;
    bus.loadAddr = 32'd0;
    bus.loadData = 32'd0;
    for (int i = 0; i < DEPTH; i++) parity_bad[i] = 1'b0;

    // Reset held with a pending request.
    #12;
    checkOutput("reset rspValid", 32'(bus.rspValid), 32'd0);
    checkOutput("reset rspData", bus.rspData, 32'd0);
    checkOutput("reset rspFault", 32'(bus.rspFault), 32'd0);
    checkOutput("reset reqReady", 32'(bus.reqReady), 32'd1);
    @(posedge clk);
    #1;
    bus.reqValid = 1'b0;
    resetN       = 1'b1;

    // Preload every word, with random junk in the ignored low address bits.
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 32'(i * 4) + $urandom_range(0, 3), $urandom);
    // Out-of-range loads are dropped.
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 32'h100, 32'hDEADBEEF);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 32'h8000_0004, 32'hBADC0DE5);
    applyStimulus(1'b1, 32'h0, 1'b1, 1'b0, 32'd0, 32'd0);
    applyStimulus(1'b1, 32'h4, 1'b1, 1'b0, 32'd0, 32'd0);

    // Load then fetch.
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 32'h08, 32'hE3A01005);
    applyStimulus(1'b1, 32'h08, 1'b1, 1'b0, 32'd0, 32'd0);
    // Faults: misaligned, out of range, both.
    applyStimulus(1'b1, 32'h06, 1'b1, 1'b0, 32'd0, 32'd0);
    applyStimulus(1'b1, 32'h100, 1'b1, 1'b0, 32'd0, 32'd0);
    applyStimulus(1'b1, 32'h101, 1'b1, 1'b0, 32'd0, 32'd0);
    applyStimulus(1'b1, 32'hFC, 1'b1, 1'b0, 32'd0, 32'd0);

    // Stall for three cycles with a request waiting, then release.
    applyStimulus(1'b1, 32'h04, 1'b1, 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h0C, 1'b0, 1'b0, 32'd0, 32'd0);
    applyStimulus(1'b1, 32'h0C, 1'b1, 1'b0, 32'd0, 32'd0);
    idle(2);

    // Same-cycle load and fetch of one word returns the old contents.
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 32'h10, 32'hAAAA5555);
    applyStimulus(1'b1, 32'h10, 1'b1, 1'b1, 32'h10, 32'h12345678);
    applyStimulus(1'b1, 32'h10, 1'b1, 1'b0, 32'd0, 32'd0);
    idle(2);

    // Reset while a response is outstanding: response lost, array kept.
    applyStimulus(1'b1, 32'h20, 1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk);
    #1;
    bus.reqValid = 1'b0;
    #1;
    resetN = 1'b0;
    #1;
    checkOutput("midreset rspValid", 32'(bus.rspValid), 32'd0);
    checkOutput("midreset rspData", bus.rspData, 32'd0);
    @(posedge clk);
    #1;
    resetN       = 1'b1;
    bus.rspReady = 1'b1;
    applyStimulus(1'b1, 32'h20, 1'b1, 1'b0, 32'd0, 32'd0);
    applyStimulus(1'b1, 32'h10, 1'b1, 1'b0, 32'd0, 32'd0);
    idle(2);

`ifdef INSTR_MEM_PARITY_EN
    // Corrupt one stored bit and fetch it, then repair by reloading.
    dut.u_array.mem_q[5] = dut.u_array.mem_q[5] ^ 33'd1;
    parity_bad[5] = 1'b1;
    applyStimulus(1'b1, 32'h14, 1'b1, 1'b0, 32'd0, 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 32'h14, 32'h0F0F0F0F);
    applyStimulus(1'b1, 32'h14, 1'b1, 1'b0, 32'd0, 32'd0);
    idle(2);
`endif

    // Randomized traffic: mixed address classes, loads and backpressure.
    for (int i = 0; i < 400; i++) begin
      kind = $urandom_range(0, 9);
      if (kind < 7)       ra = {24'd0, 6'($urandom_range(0, DEPTH - 1)), 2'b00};
      else if (kind == 7) ra = {24'd0, 6'($urandom), 2'($urandom_range(1, 3))};
      else if (kind == 8) ra = 32'h100 | ($urandom & 32'hFFFF_FFFC);
      else                ra = $urandom;
      if ($urandom_range(0, 4) == 0) la = $urandom | 32'h100;
      else                           la = 32'($urandom_range(0, 255));
      applyStimulus(1'($urandom_range(0, 1)), ra, ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 4) == 0), la, $urandom);
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
